hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: ID/EX hazard inputs, memory busy,
// stall/flush controls, timeout flag and performance counters.
interface hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        dmem_busy;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        ex_mem_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_timeout;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_events;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_branch_taken, dmem_busy,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_flush, mem_timeout, perf_stall_cycles, perf_flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_branch_taken, dmem_busy,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_flush, mem_timeout, perf_stall_cycles, perf_flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch redirect flushes, data
// memory wait stalls with sticky timeout. Optional counters: HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MEMWAIT, REDIRECT} state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_next;
    logic       mem_timeout_q;
    logic       load_use;
    logic       stall_all, pc_stall, if_id_stall, if_id_flush, id_ex_flush;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        stall_all   = 1'b0;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        case (state)
            REDIRECT: begin
                // Kill the wrong-path fetch; flush wins over stall on IF/ID.
                if_id_flush = 1'b1;
                if (hz.dmem_busy) stall_all  = 1'b1;
                else              state_next = RUN;
            end
            default: begin
                // MEMWAIT without busy evaluates exactly like RUN.
                if (hz.dmem_busy) begin
                    stall_all  = 1'b1;
                    state_next = MEMWAIT;
                end else if (hz.ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_next  = REDIRECT;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    state_next  = RUN;
                end else begin
                    state_next = RUN;
                end
            end
        endcase
        if (!rst) begin
            state_next  = RUN;
            stall_all   = 1'b0;
            pc_stall    = 1'b0;
            if_id_stall = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign wait_next = !hz.dmem_busy      ? 8'd0 :
                       (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= RUN;
            wait_cnt      <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state         <= state_next;
            wait_cnt      <= wait_next;
            // Sticky: set on the edge where the count reaches the limit.
            if (wait_next >= TIMEOUT_LIM) mem_timeout_q <= 1'b1;
        end
    end

    assign hz.pc_stall     = stall_all | pc_stall;
    assign hz.if_id_stall  = stall_all | if_id_stall;
    assign hz.id_ex_stall  = stall_all;
    assign hz.ex_mem_stall = stall_all;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.mem_timeout  = mem_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_ctr, flush_ctr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_ctr <= 32'd0;
            flush_ctr <= 32'd0;
        end else begin
            if (hz.pc_stall) stall_ctr <= stall_ctr + 32'd1;
            if (state == RUN && state_next == REDIRECT) flush_ctr <= flush_ctr + 32'd1;
        end
    end

    assign hz.perf_stall_cycles = stall_ctr;
    assign hz.perf_flush_events = flush_ctr;
`else
    assign hz.perf_stall_cycles = 32'd0;
    assign hz.perf_flush_events = 32'd0;
`endif

endmodule
